// File: rtl/fir_stream_dec_if.sv
// ---------------------------------------------------------------------------
// fir_stream_dec_if
//   Sample-in / filtered-out stream bundle for fir_stream_dec.
//
//   Handshake: a sample moves on a rising clk edge where data_valid and
//   data_ready are both high. data_ready does not depend on data_valid.
//   The source holds data stable while data_valid is high and data_ready is
//   low. fir_valid is a one-cycle strobe with no ready. fir_d holds its value
//   between strobes.
//
//   Signals:
//     data_valid  source -> filter  sample offered
//     data        source -> filter  signed sample, DW bits
//     data_ready  filter -> source  filter can take a sample this cycle
//     fir_valid   filter -> sink    one-cycle output strobe
//     fir_d       filter -> sink    signed filtered output, OW bits
//
//   Modports: master = sample source / result sink (the environment),
//             slave  = the filter.
// ---------------------------------------------------------------------------
interface fir_stream_dec_if #(
   parameter int DW = 16,
   parameter int OW = 16
);
   logic                 data_valid;
   logic signed [DW-1:0] data;
   logic                 data_ready;
   logic                 fir_valid;
   logic signed [OW-1:0] fir_d;

   modport master (
      output data_valid, data,
      input  data_ready, fir_valid, fir_d
   );

   modport slave (
      input  data_valid, data,
      output data_ready, fir_valid, fir_d
   );
endinterface

// File: rtl/fir_stream_dec.sv
// ---------------------------------------------------------------------------
// fir_stream_dec
//   Streaming real-input FIR filter with a single serial MAC, runtime
//   loadable coefficients, run-time decimation 1..15, and a rounded,
//   saturated output.
//   y[n] = sum_{k=0..TAPS-1} h[k] * x[n-k]. Only every D-th accepted sample
//   starts a MAC pass, where D = max(decim, 1).
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-low reset (also clears coefficients)
//     coef_wr    coefficient write strobe (honoured only in IDLE)
//     coef_addr  tap index k
//     coef_data  coefficient h[k], signed, FRAC fractional bits
//     coef_err   one-cycle pulse: a write was dropped because busy
//     decim      decimation factor, 0 treated as 1, quasi-static
//     flush      in IDLE: clear delay line, pointer and decimation counter
//     busy       high in MAC or OUT
//     state_dbg  current FSM state (0 IDLE, 1 MAC, 2 OUT)
//     strm       sample / result stream (slave side)
// ---------------------------------------------------------------------------
module fir_stream_dec #(
   parameter int DW   = 16,
   parameter int CW   = 20,
   parameter int FRAC = 16,
   parameter int TAPS = 32,
   parameter int OW   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      coef_wr,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic signed [CW-1:0]      coef_data,
   output logic                      coef_err,
   input  logic [3:0]                decim,
   input  logic                      flush,
   output logic                      busy,
   output logic [1:0]                state_dbg,
   fir_stream_dec_if.slave           strm
);

   localparam int AW   = $clog2(TAPS);
   // Wide enough that TAPS full-scale products can never overflow.
   localparam int ACCW = DW + CW + AW;

   localparam logic signed [ACCW-1:0] RND     = {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic signed [CW-1:0]   coef_mem [TAPS];
   logic signed [DW-1:0]   dline    [TAPS];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          base_ptr;   // slot of the newest sample of this pass
   logic [AW-1:0]          tap_k;
   logic [AW-1:0]          rd_idx;
   logic [3:0]             dec_cnt;
   logic signed [ACCW-1:0] acc;
   logic signed [DW+CW-1:0] prod;
   logic signed [ACCW-1:0] rnd;
   logic signed [ACCW-1:0] shr;
   logic signed [OW-1:0]   sat;
   logic signed [OW-1:0]   fir_d_q;
   logic                   fir_valid_q;

   logic       data_ready_c;
   logic       accept;
   logic       start_mac;
   logic       last_tap;
   logic [3:0] d_eff;
   logic [3:0] cnt_eff;
   logic [3:0] cnt_nx;

   // Decimation count. A count left over from a larger D is treated as 0,
   // so a decim change is picked up at the next count-0 comparison.
   always_comb begin
      d_eff   = (decim == 4'd0) ? 4'd1 : decim;
      cnt_eff = (dec_cnt >= d_eff) ? 4'd0 : dec_cnt;
      cnt_nx  = (cnt_eff + 4'd1 == d_eff) ? 4'd0 : cnt_eff + 4'd1;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start_mac) state_nx = S_MAC;
         S_MAC:   if (last_tap)  state_nx = S_OUT;
         S_OUT:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      data_ready_c = 1'b0;
      busy         = 1'b0;
      last_tap     = 1'b0;
      case (state)
         S_IDLE: data_ready_c = !flush;   // a flush cycle takes no sample
         S_MAC: begin
            busy     = 1'b1;
            last_tap = (tap_k == AW'(TAPS-1));
         end
         S_OUT:  busy = 1'b1;
         default: ;
      endcase
   end

   assign state_dbg       = state;
   assign accept          = strm.data_valid & data_ready_c;
   assign start_mac       = accept & (cnt_eff == 4'd0);
   assign strm.data_ready = data_ready_c;
   assign strm.fir_valid  = fir_valid_q;
   assign strm.fir_d      = fir_d_q;

   // Tap k multiplies the sample k steps older than the newest one.
   assign rd_idx = base_ptr - tap_k;
   assign prod   = dline[rd_idx] * coef_mem[tap_k];

   // Round half toward +inf, then clamp to the OW-bit signed range.
   always_comb begin
      rnd = acc + RND;
      shr = rnd >>> FRAC;
      if (shr > SAT_MAX)      sat = {1'b0, {(OW-1){1'b1}}};
      else if (shr < SAT_MIN) sat = {1'b1, {(OW-1){1'b0}}};
      else                    sat = shr[OW-1:0];
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) begin
            coef_mem[i] <= '0;
            dline[i]    <= '0;
         end
         wr_ptr      <= '0;
         base_ptr    <= '0;
         tap_k       <= '0;
         dec_cnt     <= '0;
         acc         <= '0;
         fir_d_q     <= '0;
         fir_valid_q <= 1'b0;
         coef_err    <= 1'b0;
      end else begin
         fir_valid_q <= 1'b0;
         coef_err    <= coef_wr & (state != S_IDLE);

         // Written at the same edge as a possible accept, so a MAC pass
         // started in this cycle already sees the new coefficient.
         if (coef_wr && state == S_IDLE) coef_mem[coef_addr] <= coef_data;

         case (state)
            S_IDLE: begin
               if (flush) begin
                  for (int i = 0; i < TAPS; i++) dline[i] <= '0;
                  wr_ptr  <= '0;
                  dec_cnt <= '0;
               end else if (accept) begin
                  dline[wr_ptr] <= strm.data;
                  wr_ptr        <= wr_ptr + AW'(1);
                  dec_cnt       <= cnt_nx;
                  if (start_mac) begin
                     base_ptr <= wr_ptr;
                     tap_k    <= '0;
                     acc      <= '0;
                  end
               end
            end
            S_MAC: begin
               acc   <= acc + ACCW'(prod);
               tap_k <= tap_k + AW'(1);
            end
            S_OUT: begin
               fir_d_q     <= sat;
               fir_valid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_stream_dec.sv
// ---------------------------------------------------------------------------
// tb_fir_stream_dec
//   Self-checking bench for fir_stream_dec. A behavioural model (coefficient
//   array, sample history queue, plain convolution sum) predicts every
//   output and the busy window of each MAC pass.
// ---------------------------------------------------------------------------
module tb_fir_stream_dec;

   localparam int DW   = 16;
   localparam int CW   = 20;
   localparam int FRAC = 16;
   localparam int TAPS = 32;
   localparam int OW   = 16;
   localparam int AW   = $clog2(TAPS);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;   // number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   logic                 coef_wr   = 1'b0;
   logic [AW-1:0]        coef_addr = '0;
   logic signed [CW-1:0] coef_data = '0;
   logic                 coef_err;
   logic [3:0]           decim     = 4'd1;
   logic                 flush     = 1'b0;
   logic                 busy;
   logic [1:0]           state_dbg;

   fir_stream_dec_if #(.DW(DW), .OW(OW)) sig ();

   fir_stream_dec #(
      .DW(DW), .CW(CW), .FRAC(FRAC), .TAPS(TAPS), .OW(OW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .coef_wr   (coef_wr),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .coef_err  (coef_err),
      .decim     (decim),
      .flush     (flush),
      .busy      (busy),
      .state_dbg (state_dbg),
      .strm      (sig)
   );

   // ---------------- reference model ----------------
   longint               h [TAPS];
   longint               hist[$];      // newest sample at index 0
   logic signed [OW-1:0] exp_q[$];
   int                   lat_q[$];     // accept edge number of each pending pass
   int                   busy_start = -1000;
   int                   mcnt = 0;
   logic signed [OW-1:0] last_fir = '0;
   int                   n_tests = 0;
   int                   n_fail = 0;
   int                   n_strobes = 0;
   logic signed [OW-1:0] mon_e;
   int                   mon_a;

   task automatic check(input string tag, input longint got, input longint expv);
      n_tests++;
      if (got != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   // The DUT is in MAC/OUT during cycles a .. a+TAPS after accept edge a.
   function automatic bit is_busy();
      return (cyc >= busy_start) && (cyc <= busy_start + TAPS);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < TAPS; k++) h[k] = 0;
      hist.delete();
      exp_q.delete();
      lat_q.delete();
      busy_start = -1000;
      mcnt       = 0;
      last_fir   = '0;
   endtask

   task automatic model_accept(input logic signed [DW-1:0] v);
      int     d;
      longint acc;
      d = (decim == 4'd0) ? 1 : int'(decim);
      if (mcnt >= d) mcnt = 0;
      hist.push_front(longint'(v));
      if (hist.size() > TAPS) void'(hist.pop_back());
      if (mcnt == 0) begin
         acc = 0;
         for (int k = 0; k < hist.size(); k++) acc += h[k] * hist[k];
         acc = (acc + (longint'(1) <<< (FRAC-1))) >>> FRAC;
         if (acc > 32767)  acc = 32767;
         if (acc < -32768) acc = -32768;
         exp_q.push_back(OW'(acc));
         lat_q.push_back(cyc + 1);
         busy_start = cyc + 1;
      end
      mcnt = (mcnt + 1 == d) ? 0 : mcnt + 1;
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      #2;
      if (rst) begin
         check("data_ready", longint'(sig.data_ready), longint'(!is_busy() && !flush));
         check("busy", longint'(busy), longint'(is_busy()));
         if (sig.fir_valid) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               mon_a = lat_q.pop_front();
               check("fir_d", longint'(sig.fir_d), longint'(mon_e));
               check("latency", longint'(cyc - mon_a), longint'(TAPS + 1));
               last_fir = mon_e;
            end
         end else begin
            check("fir_d_hold", longint'(sig.fir_d), longint'(last_fir));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic signed [DW-1:0] v, input bit wr = 1'b0,
                       input int k = 0, input longint c = 0);
      bit done = 1'b0;
      @(negedge clk);
      sig.data_valid = 1'b1;
      sig.data       = v;
      if (wr) begin
         coef_wr   = 1'b1;
         coef_addr = AW'(k);
         coef_data = CW'(c);
      end
      #1;
      for (int n = 0; n < 200 && !done; n++) begin
         if (sig.data_ready) begin
            if (wr) h[k] = c;
            model_accept(v);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         coef_wr = 1'b0;
         if (!done) begin
            @(negedge clk);
            #1;
         end
      end
      if (!done) begin
         check("send_timeout", 0, 1);
         sig.data_valid = 1'b0;
      end
   endtask

   task automatic write_coef(input int k, input longint c);
      bit b;
      @(negedge clk);
      sig.data_valid = 1'b0;
      coef_wr   = 1'b1;
      coef_addr = AW'(k);
      coef_data = CW'(c);
      #1;
      b = is_busy();
      if (!b) h[k] = c;
      @(negedge clk);
      coef_wr = 1'b0;
      #1;
      check("coef_err", longint'(coef_err), longint'(b));
   endtask

   task automatic flush_dl();
      @(negedge clk);
      sig.data_valid = 1'b0;
      flush = 1'b1;
      #1;
      if (!is_busy()) begin
         hist.delete();
         mcnt = 0;
      end
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      @(negedge clk);
      sig.data_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      sig.data_valid = 1'b0;
      while ((exp_q.size() != 0 || is_busy()) && n < 400) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain_timeout", longint'(n < 400), 1);
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      rst            = 1'b0;
      sig.data_valid = 1'b0;
      coef_wr        = 1'b0;
      flush          = 1'b0;
      model_clear();
      #1;
      check("rst_fir_valid", longint'(sig.fir_valid), 0);
      check("rst_fir_d", longint'(sig.fir_d), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_coef_err", longint'(coef_err), 0);
      check("rst_state", longint'(state_dbg), 0);
      repeat (hold) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_ready", longint'(sig.data_ready), 1);
   endtask

   // Impulse coefficients (k+1)<<12 with a 1600 impulse give outputs
   // 100, 200, ..., 3200 while every h[k] fits the signed coefficient width.
   task automatic load_impulse_coefs();
      for (int k = 0; k < TAPS; k++) write_coef(k, longint'(k + 1) <<< 12);
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      int                   s0;
      logic signed [CW-1:0] cv;
      logic signed [DW-1:0] dv;

      sig.data_valid = 1'b0;
      sig.data       = '0;
      #1 rst = 1'b0;
      do_reset(3);

      // Impulse response
      decim = 4'd1;
      load_impulse_coefs();
      s0 = n_strobes;
      send(16'sd1600);
      for (int i = 0; i < TAPS - 1; i++) send(16'sd0);
      wait_idle();
      check("impulse_strobes", longint'(n_strobes - s0), TAPS);
      check("impulse_last", longint'(sig.fir_d), 3200);

      // Saturation at both rails
      for (int k = 0; k < TAPS; k++) write_coef(k, 65536);
      flush_dl();
      for (int i = 0; i < TAPS; i++) send(16'sd32767);
      wait_idle();
      check("sat_pos", longint'(sig.fir_d), 32767);
      for (int i = 0; i < TAPS; i++) send(-16'sd32768);
      wait_idle();
      check("sat_neg", longint'(sig.fir_d), -32768);

      // Rounding half toward +inf with h[0] = 0.5
      write_coef(0, 32'h8000);
      for (int k = 1; k < TAPS; k++) write_coef(k, 0);
      flush_dl();
      send(16'sd3);  wait_idle(); check("round_p3", longint'(sig.fir_d), 2);
      send(-16'sd3); wait_idle(); check("round_m3", longint'(sig.fir_d), -1);
      send(16'sd1);  wait_idle(); check("round_p1", longint'(sig.fir_d), 1);
      send(-16'sd1); wait_idle(); check("round_m1", longint'(sig.fir_d), 0);

      // Decimation by 4 with data_valid held high
      for (int k = 0; k < TAPS; k++) begin
         cv = CW'($urandom);
         write_coef(k, longint'(cv));
      end
      flush_dl();
      decim = 4'd4;
      s0 = n_strobes;
      for (int i = 0; i < 8; i++) send(DW'($urandom));
      wait_idle();
      check("decim_strobes", longint'(n_strobes - s0), 2);
      decim = 4'd1;

      // Write and flush while busy are dropped; flush in IDLE clears history
      load_impulse_coefs();
      flush_dl();
      send(16'sd1000);
      write_coef(3, 12345);
      flush_dl();
      for (int i = 0; i < 3; i++) send(16'sd0);
      wait_idle();
      check("busy_write_kept", longint'(sig.fir_d), 250);
      flush_dl();
      send(16'sd500);
      send(16'sd0);
      wait_idle();
      check("flush_clean", longint'(sig.fir_d), 63);

      // Coefficient write and sample accept in the same cycle
      flush_dl();
      send(16'sd800, 1'b1, 0, longint'(3) <<< 16);
      wait_idle();
      check("wr_with_accept", longint'(sig.fir_d), 2400);

      // Randomised traffic
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 39) == 0) decim = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) begin
            cv = CW'($urandom);
            write_coef(int'($urandom_range(0, TAPS - 1)), longint'(cv));
         end
         if ($urandom_range(0, 49) == 0) flush_dl();
         if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(0, 5)));
         dv = DW'($urandom);
         send(dv);
      end
      wait_idle();
      decim = 4'd1;

      // Reset in the middle of a MAC pass
      load_impulse_coefs();
      flush_dl();
      send(16'sd100);
      repeat (10) @(negedge clk);
      do_reset(3);
      check("mid_mac_fir_d", longint'(sig.fir_d), 0);
      idle_cycles(40);
      send(16'sd100);
      wait_idle();
      check("post_reset_impulse", longint'(sig.fir_d), 0);

      check("leftover_expected", longint'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got no finish expected finish before cycle %0d", cyc);
      $fatal(1, "simulation time limit reached");
   end

endmodule
